ecc_apb_sequencer: RTL and testbench

- Upstream job sequencer for the APB-controlled ECC encode/decode/full-channel core.
- Accepts one job per valid/ready handshake and converts it into ordered APB write transfers (DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL last, which launches the operation).
- Waits for operation_done with a timeout and returns data_out and num_of_errors through a valid/ready result port.
- Sits between the test/system host and the ECC core; it is the core's only APB master.

---
 rtl/ecc_pkg.sv | 49 ++++
 rtl/apb_write_master.sv | 46 ++++
 rtl/ecc_apb_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_ecc_apb_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared constants and types for the ECC core APB sequencer: register map,
// op/width codes, timeout error code and the sequencer state/entry encodings.
package ecc_pkg;

    localparam int unsigned CTRL_OFS     = 32'h0;
    localparam int unsigned DATA_IN_OFS  = 32'h4;
    localparam int unsigned CW_WIDTH_OFS = 32'h8;
    localparam int unsigned NOISE_OFS    = 32'hC;

    typedef enum logic [1:0] {
        OP_ENC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_FULL = 2'b10
    } op_t;

    typedef enum logic [1:0] {
        W8  = 2'b00,
        W16 = 2'b01,
        W32 = 2'b10
    } width_t;

    localparam logic [1:0] TIMEOUT_ERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WAIT_DONE,
        S_RESULT
    } seq_state_t;

    // Write-list entries in issue order; CTRL is always last since it launches the core.
    typedef enum logic [1:0] {
        E_DATA,
        E_WIDTH,
        E_NOISE,
        E_CTRL
    } wr_entry_t;

    function automatic int unsigned entry_ofs(input wr_entry_t e);
        case (e)
            E_DATA:  return DATA_IN_OFS;
            E_WIDTH: return CW_WIDTH_OFS;
            E_NOISE: return NOISE_OFS;
            default: return CTRL_OFS;
        endcase
    endfunction

endpackage

// File: rtl/apb_write_master.sv
// Single-transfer APB write engine: a start pulse launches SETUP next cycle,
// ACCESS follows, and done is high during ACCESS. Start during ACCESS chains transfers.
module apb_write_master #(
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned AMBA_WORD       = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0] IDLE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [AMBA_ADDR_WIDTH-1:0] addr,
    input  logic [AMBA_WORD-1:0]       data,
    output logic                       done,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else if (start) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= addr;
            PWDATA  <= data;
        end else if (PSEL && !PENABLE) begin
            PENABLE <= 1'b1;
        end else begin
            // Park on DATA_IN so the bus never rests on the CTRL offset.
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PADDR   <= IDLE_ADDR;
            PWDATA  <= '0;
        end
    end

    assign PWRITE = PSEL;
    assign done   = PSEL && PENABLE;

endmodule

// File: rtl/ecc_apb_sequencer.sv
// Job sequencer for the APB ECC core: turns each accepted job into ordered
// register writes, waits for operation_done (with timeout) and returns the result.
//
// state       | meaning
// S_IDLE      | job_ready high, waiting for job_valid
// S_SETUP     | APB setup phase of the current write entry
// S_ACCESS    | APB access phase; chain next entry or finish after CTRL
// S_WAIT_DONE | core running, timeout counter advancing
// S_RESULT    | res_valid high, outputs held until res_ready
module ecc_apb_sequencer
    import ecc_pkg::*;
#(
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [1:0]                 job_op,
    input  logic [1:0]                 job_width,
    input  logic [DATA_WIDTH-1:0]      job_data,
    input  logic [DATA_WIDTH-1:0]      job_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic [1:0]                 res_errors,
    output logic                       res_timeout,
    output logic                       busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [AMBA_ADDR_WIDTH-1:0] entry_addr(input wr_entry_t e);
        return AMBA_ADDR_WIDTH'(BASE_ADDR + entry_ofs(e));
    endfunction

    seq_state_t state, state_nxt;
    wr_entry_t  entry, entry_nxt, follow;

    logic [1:0]                 op_q, width_q;
    logic [DATA_WIDTH-1:0]      data_q, noise_q;
    logic                       need_width, need_noise;
    logic                       shadow_valid;
    logic [1:0]                 shadow_width;
    logic [CNT_W-1:0]           cnt;
    logic                       timeout_hit;

    logic                       wr_start, wr_done;
    logic [AMBA_ADDR_WIDTH-1:0] wr_addr;
    logic [AMBA_WORD-1:0]       wr_data, follow_data;

    apb_write_master #(
        .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH),
        .AMBA_WORD       (AMBA_WORD),
        .IDLE_ADDR       (AMBA_ADDR_WIDTH'(BASE_ADDR + DATA_IN_OFS))
    ) u_apb (
        .clk     (clk),
        .rst     (rst),
        .start   (wr_start),
        .addr    (wr_addr),
        .data    (wr_data),
        .done    (wr_done),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE)
    );

    assign timeout_hit = (state == S_WAIT_DONE) && (cnt == CNT_LAST);

    always_comb begin
        follow = E_CTRL;
        case (entry)
            E_DATA:  follow = need_width ? E_WIDTH : (need_noise ? E_NOISE : E_CTRL);
            E_WIDTH: follow = need_noise ? E_NOISE : E_CTRL;
            default: follow = E_CTRL;
        endcase
        case (follow)
            E_WIDTH: follow_data = AMBA_WORD'(width_q);
            E_NOISE: follow_data = AMBA_WORD'(noise_q);
            E_CTRL:  follow_data = AMBA_WORD'(op_q);
            default: follow_data = AMBA_WORD'(data_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            entry <= E_DATA;
        end else begin
            state <= state_nxt;
            entry <= entry_nxt;
        end
    end

    // The first write is launched from IDLE so SETUP lands on the cycle after acceptance.
    always_comb begin
        state_nxt = state;
        entry_nxt = entry;
        wr_start  = 1'b0;
        wr_addr   = entry_addr(E_DATA);
        wr_data   = '0;
        case (state)
            S_IDLE: begin
                if (job_valid) begin
                    state_nxt = S_SETUP;
                    entry_nxt = E_DATA;
                    wr_start  = 1'b1;
                    wr_data   = AMBA_WORD'(job_data);
                end
            end
            S_SETUP: state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (wr_done) begin
                    if (entry == E_CTRL) begin
                        state_nxt = S_WAIT_DONE;
                    end else begin
                        state_nxt = S_SETUP;
                        entry_nxt = follow;
                        wr_start  = 1'b1;
                        wr_addr   = entry_addr(follow);
                        wr_data   = follow_data;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (operation_done || timeout_hit) state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q         <= '0;
            width_q      <= '0;
            data_q       <= '0;
            noise_q      <= '0;
            need_width   <= 1'b0;
            need_noise   <= 1'b0;
            shadow_valid <= 1'b0;
            shadow_width <= '0;
            cnt          <= '0;
            res_data     <= '0;
            res_errors   <= '0;
            res_timeout  <= 1'b0;
        end else begin
            if (state == S_IDLE && job_valid) begin
                op_q       <= job_op;
                width_q    <= job_width;
                data_q     <= job_data;
                noise_q    <= job_noise;
                need_width <= !shadow_valid || (shadow_width != job_width);
                need_noise <= (job_op == OP_FULL);
            end
            if (state == S_ACCESS) begin
                cnt <= '0;
            end else if (state == S_WAIT_DONE) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == S_ACCESS && wr_done && entry == E_CTRL) begin
                shadow_valid <= 1'b1;
                shadow_width <= width_q;
            end
            // A timed-out core is in an unknown state, so force a width rewrite next job.
            if (state == S_WAIT_DONE) begin
                if (operation_done) begin
                    res_data    <= data_out;
                    res_errors  <= num_of_errors;
                    res_timeout <= 1'b0;
                end else if (timeout_hit) begin
                    res_data     <= '0;
                    res_errors   <= TIMEOUT_ERR;
                    res_timeout  <= 1'b1;
                    shadow_valid <= 1'b0;
                end
            end
        end
    end

    assign job_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_RESULT);

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Directed bench for ecc_apb_sequencer: table of jobs with hand-computed APB
// write lists and results, plus backpressure and mid-transfer reset sequences.
module tb_ecc_apb_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [1:0]  job_op = '0;
    logic [1:0]  job_width = '0;
    logic [31:0] job_data = '0;
    logic [31:0] job_noise = '0;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic        operation_done = 1'b0;
    logic [31:0] data_out = 32'hDEADBEEF;
    logic [1:0]  num_of_errors = 2'b10;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [1:0]  res_errors;
    logic        res_timeout;
    logic        busy;

    int errors = 0;
    int checks = 0;

    ecc_apb_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_op         (job_op),
        .job_width      (job_width),
        .job_data       (job_data),
        .job_noise      (job_noise),
        .PADDR          (PADDR),
        .PWDATA         (PWDATA),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .operation_done (operation_done),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_errors     (res_errors),
        .res_timeout    (res_timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  width;
        logic [31:0] data;
        logic [31:0] noise;
        int          n_wr;
        logic [19:0] wa [4];
        logic [31:0] wd [4];
        int          done_dly;
        logic [31:0] core_data;
        logic [1:0]  core_err;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        logic        exp_to;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [1:0] op, input logic [1:0] w,
                        input logic [31:0] d, input logic [31:0] nz, input int n,
                        input logic [19:0] a0, input logic [31:0] d0,
                        input logic [19:0] a1, input logic [31:0] d1,
                        input logic [19:0] a2, input logic [31:0] d2,
                        input logic [19:0] a3, input logic [31:0] d3,
                        input int dly, input logic [31:0] cd, input logic [1:0] ce,
                        input logic [31:0] ed, input logic [1:0] ee, input logic et);
        tbl[i].op = op;  tbl[i].width = w;  tbl[i].data = d;  tbl[i].noise = nz;
        tbl[i].n_wr = n;
        tbl[i].wa[0] = a0; tbl[i].wd[0] = d0;
        tbl[i].wa[1] = a1; tbl[i].wd[1] = d1;
        tbl[i].wa[2] = a2; tbl[i].wd[2] = d2;
        tbl[i].wa[3] = a3; tbl[i].wd[3] = d3;
        tbl[i].done_dly = dly; tbl[i].core_data = cd; tbl[i].core_err = ce;
        tbl[i].exp_data = ed;  tbl[i].exp_err = ee;   tbl[i].exp_to = et;
    endtask

    task automatic present_job(input int i);
        job_op    = tbl[i].op;
        job_width = tbl[i].width;
        job_data  = tbl[i].data;
        job_noise = tbl[i].noise;
        job_valid = 1'b1;
    endtask

    // Entered at the negedge of the first SETUP cycle; leaves at the negedge of the first RESULT cycle.
    task automatic run_body(input int i);
        int n;
        for (int k = 0; k < tbl[i].n_wr; k++) begin
            chk($sformatf("setup v%0d w%0d", i, k), {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                {3'b101, tbl[i].wa[k], tbl[i].wd[k]});
            @(negedge clk);
            chk($sformatf("access v%0d w%0d", i, k), {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                {3'b111, tbl[i].wa[k], tbl[i].wd[k]});
            @(negedge clk);
        end
        chk($sformatf("idle bus v%0d", i), {PSEL, PENABLE, PWRITE, PADDR}, {3'b000, 20'h4});
        chk($sformatf("wait status v%0d", i), {busy, job_ready, res_valid}, 3'b100);
        if (tbl[i].done_dly >= 0) begin
            repeat (tbl[i].done_dly) @(negedge clk);
            operation_done = 1'b1;
            data_out       = tbl[i].core_data;
            num_of_errors  = tbl[i].core_err;
            @(negedge clk);
            operation_done = 1'b0;
            data_out       = 32'hDEADBEEF;
            num_of_errors  = 2'b10;
        end else begin
            n = 0;
            while (!res_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("timeout latency v%0d", i), 64'(n), 64'd64);
        end
        chk($sformatf("result v%0d", i), {res_valid, res_timeout, res_errors, res_data},
            {1'b1, tbl[i].exp_to, tbl[i].exp_err, tbl[i].exp_data});
    endtask

    task automatic release_result(input int i);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk($sformatf("release v%0d", i), {res_valid, job_ready, busy}, 3'b010);
    endtask

    task automatic run_vec(input int i);
        chk($sformatf("ready v%0d", i), {job_ready, busy}, 2'b10);
        present_job(i);
        @(negedge clk);
        job_valid = 1'b0;
        run_body(i);
        release_result(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        //   i  op     w      data         noise        n  writes (addr,data) x4                                   dly core        err    exp_data     err    to
        setv(0, 2'b00, 2'b00, 32'h5,       32'h0,       3, 20'h4, 32'h5,  20'h8, 32'h0, 20'h0, 32'h0, 20'h0, 32'h0,  2, 32'h2D,     2'b00, 32'h2D,     2'b00, 1'b0);
        setv(1, 2'b00, 2'b00, 32'hA,       32'hFFFF,    2, 20'h4, 32'hA,  20'h0, 32'h0, 20'h0, 32'h0, 20'h0, 32'h0,  0, 32'h55,     2'b00, 32'h55,     2'b00, 1'b0);
        setv(2, 2'b00, 2'b10, 32'h3,       32'h0,       3, 20'h4, 32'h3,  20'h8, 32'h2, 20'h0, 32'h0, 20'h0, 32'h0,  5, 32'h1234,   2'b00, 32'h1234,   2'b00, 1'b0);
        setv(3, 2'b10, 2'b01, 32'hAB,      32'h1,       4, 20'h4, 32'hAB, 20'h8, 32'h1, 20'hC, 32'h1, 20'h0, 32'h2,  1, 32'hAA,     2'b01, 32'hAA,     2'b01, 1'b0);
        setv(4, 2'b01, 2'b01, 32'h77,      32'h0,       2, 20'h4, 32'h77, 20'h0, 32'h1, 20'h0, 32'h0, 20'h0, 32'h0,  3, 32'h7,      2'b10, 32'h7,      2'b10, 1'b0);
        setv(5, 2'b00, 2'b01, 32'h9,       32'h0,       2, 20'h4, 32'h9,  20'h0, 32'h0, 20'h0, 32'h0, 20'h0, 32'h0, -1, 32'h0,      2'b00, 32'h0,      2'b11, 1'b1);
        setv(6, 2'b00, 2'b01, 32'h9,       32'h0,       3, 20'h4, 32'h9,  20'h8, 32'h1, 20'h0, 32'h0, 20'h0, 32'h0,  0, 32'h33,     2'b00, 32'h33,     2'b00, 1'b0);
        setv(7, 2'b00, 2'b01, 32'h1,       32'h0,       2, 20'h4, 32'h1,  20'h0, 32'h0, 20'h0, 32'h0, 20'h0, 32'h0,  1, 32'h11,     2'b00, 32'h11,     2'b00, 1'b0);
        setv(8, 2'b01, 2'b01, 32'h2,       32'h0,       2, 20'h4, 32'h2,  20'h0, 32'h1, 20'h0, 32'h0, 20'h0, 32'h0,  2, 32'h22,     2'b01, 32'h22,     2'b01, 1'b0);
        setv(9, 2'b00, 2'b01, 32'hF,       32'h0,       2, 20'h4, 32'hF,  20'h0, 32'h0, 20'h0, 32'h0, 20'h0, 32'h0,  0, 32'h0,      2'b00, 32'h0,      2'b00, 1'b0);
        setv(10,2'b00, 2'b01, 32'hF,       32'h0,       3, 20'h4, 32'hF,  20'h8, 32'h1, 20'h0, 32'h0, 20'h0, 32'h0,  4, 32'h99,     2'b11, 32'h99,     2'b11, 1'b0);

        repeat (2) @(negedge clk);
        chk("reset apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'h0);
        chk("reset status", {busy, job_ready, res_valid, res_timeout, res_errors, res_data}, {4'b0100, 2'b00, 32'h0});
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i <= 6; i++) begin
            if (i == 1) begin
                operation_done = 1'b1;
                @(negedge clk);
                operation_done = 1'b0;
                chk("stray done in idle", {busy, res_valid, job_ready}, 3'b001);
            end
            run_vec(i);
        end

        // Result backpressure with a job waiting behind it.
        present_job(7);
        @(negedge clk);
        job_valid = 1'b0;
        run_body(7);
        present_job(8);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("hold c%0d", c), {res_valid, job_ready, PSEL, res_timeout, res_errors, res_data},
                {3'b100, 1'b0, 2'b00, 32'h11});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("no accept on res_ready cycle", {job_ready, busy, PSEL}, 3'b100);
        @(negedge clk);
        job_valid = 1'b0;
        run_body(8);
        release_result(8);

        // Reset during the DATA_IN access, then confirm the width shadow was dropped.
        present_job(9);
        @(negedge clk);
        job_valid = 1'b0;
        chk("pre-reset setup", {PSEL, PENABLE, PADDR, PWDATA}, {2'b10, 20'h4, 32'hF});
        @(negedge clk);
        chk("pre-reset access", {PSEL, PENABLE, PADDR, PWDATA}, {2'b11, 20'h4, 32'hF});
        rst = 1'b0;
        #1;
        chk("mid reset apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'h0);
        chk("mid reset status", {busy, job_ready, res_valid}, 3'b010);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post reset quiet", {PSEL, PENABLE, busy, job_ready}, 4'b0001);
        run_vec(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
